// File: rtl/display_write_queue.sv
// display_write_queue: CPU-side pixel write FIFO feeding the double-buffered
// PSRAM display stage, plus framebuffer-flip sequencing.
//
// Writes accepted on the wr_* port are queued and drained one at a time onto
// display_addr/display_data/display_wr. Each write goes through
// WRITE (display_wr held WR_HOLD cycles), then GUARD (display_busy ignored for
// GUARD_CYCLES), then WAIT (until display_busy is low).
//
// A flip request is held pending (blocking new writes) until every write queued
// ahead of it has been issued and the display stage is idle. Only then is
// display_flip_framebuffer pulsed for FLIP_PULSE cycles.
//
// Optional feature, enabled by defining DISPLAY_FILL_EN: adds a hardware
// framebuffer fill (fill_start / fill_color / fill_busy). When enabled, the fill
// writes fill_color to word addresses 0..FB_PIXELS-1 using the same per-word
// write sequence.
//
// Entirely in the clk domain; reset_n asserts asynchronously and is expected to
// be released synchronously.
module display_write_queue #(
    parameter int DEPTH        = 16,
    parameter int WR_HOLD      = 2,
    parameter int GUARD_CYCLES = 4,
    parameter int FLIP_PULSE   = 4,
    parameter int FB_PIXELS    = 86400
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_valid,
    input  logic [19:0]              wr_addr,
    input  logic [15:0]              wr_data,
    output logic                     wr_ready,
    input  logic                     flip_req,
    output logic                     flip_pending,
    output logic [$clog2(DEPTH):0]   level,
`ifdef DISPLAY_FILL_EN
    input  logic                     fill_start,
    input  logic [15:0]              fill_color,
    output logic                     fill_busy,
`endif
    output logic [19:0]              display_addr,
    output logic [15:0]              display_data,
    output logic                     display_wr,
    input  logic                     display_busy,
    output logic                     display_flip_framebuffer
);

    localparam int AW = $clog2(DEPTH);

    // Terminal values for the shared phase counter (each phase counts 0..N-1).
    localparam int WR_LAST_I    = WR_HOLD - 1;
    localparam int GUARD_LAST_I = GUARD_CYCLES - 1;
    localparam int FLIP_LAST_I  = FLIP_PULSE - 1;
    localparam logic [7:0] WR_LAST    = WR_LAST_I[7:0];
    localparam logic [7:0] GUARD_LAST = GUARD_LAST_I[7:0];
    localparam logic [7:0] FLIP_LAST  = FLIP_LAST_I[7:0];
    localparam logic [7:0] CNT_ONE    = 8'd1;

    localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
    localparam logic [AW:0]   LVL_ONE    = (AW + 1)'(1'b1);

    // Reject configurations the pointer arithmetic and counters cannot handle.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WR_HOLD < 1 || WR_HOLD > 256 ||
        GUARD_CYCLES < 1 || GUARD_CYCLES > 256 || FLIP_PULSE < 1 || FLIP_PULSE > 256 ||
        FB_PIXELS < 1 || FB_PIXELS > 1048575) begin : g_bad_config
        $error("display_write_queue: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FLIP  = 3'd4
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t        state_q,        state_d;
    logic [7:0]    cnt_q,          cnt_d;
    logic [AW-1:0] wr_ptr_q,       wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,       rd_ptr_d;
    logic [AW:0]   count_q,        count_d;
    logic          flip_pending_q, flip_pending_d;
    logic [19:0]   disp_addr_q,    disp_addr_d;
    logic [15:0]   disp_data_q,    disp_data_d;
    logic          disp_wr_q,      disp_wr_d;
    logic          flip_q,         flip_d;
    logic [35:0]   mem_q [DEPTH];

    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          fill_active_s;
    logic          fill_word_s;
    logic          fill_done_s;
    logic          wr_ready_s;
    logic          push_s;
    logic          pop_s;
    logic          dispatch_ok_s;

`ifdef DISPLAY_FILL_EN
    localparam logic [19:0] FB_END   = FB_PIXELS[19:0];
    localparam logic [19:0] ADDR_ONE = 20'd1;

    logic          fill_active_q, fill_active_d;
    logic [19:0]   fill_addr_q,   fill_addr_d;
    logic [15:0]   fill_color_q,  fill_color_d;
    logic          fill_start_ok_s;
`endif

    // ---------------------------------------------------------------------
    // Status decode
    // ---------------------------------------------------------------------
    assign fifo_empty_s = (count_q == '0);
    assign fifo_full_s  = (count_q == FULL_LEVEL);

`ifdef DISPLAY_FILL_EN
    assign fill_active_s   = fill_active_q;
    assign fill_word_s     = fill_active_q && (fill_addr_q != FB_END);
    assign fill_done_s     = fill_active_q && (fill_addr_q == FB_END);
    assign fill_start_ok_s = fill_start && (state_q == ST_IDLE) && fifo_empty_s &&
                             !flip_pending_q && !fill_active_q;
`else
    assign fill_active_s = 1'b0;
    assign fill_word_s   = 1'b0;
    assign fill_done_s   = 1'b0;
`endif

    // A pending flip freezes the input so nothing can slip in ahead of it.
    assign wr_ready_s = !fifo_full_s && !flip_pending_q && !fill_active_s;
    assign push_s     = wr_valid && wr_ready_s;

    // WAIT with busy low behaves exactly like IDLE.
    // This lets the next write go out WR_HOLD+GUARD_CYCLES+1 cycles after the
    // previous one.
    assign dispatch_ok_s = !display_busy && ((state_q == ST_IDLE) || (state_q == ST_WAIT));

    // ---------------------------------------------------------------------
    // Next-state logic: sequencer, FIFO pointers, flip request, fill engine
    // ---------------------------------------------------------------------
    // Compute all next-state values for the sequencer and FIFO bookkeeping.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_ptr_d       = rd_ptr_q;
        disp_addr_d    = disp_addr_q;
        disp_data_d    = disp_data_q;
        disp_wr_d      = disp_wr_q;
        flip_d         = flip_q;
        pop_s          = 1'b0;
`ifdef DISPLAY_FILL_EN
        fill_active_d  = fill_active_q;
        fill_addr_d    = fill_addr_q;
        fill_color_d   = fill_color_q;
`endif

        // Flip requests do not stack: a request while one is pending is dropped.
        if (flip_req && !flip_pending_q) begin
            flip_pending_d = 1'b1;
        end else begin
            flip_pending_d = flip_pending_q;
        end

`ifdef DISPLAY_FILL_EN
        if (fill_start_ok_s) begin
            fill_active_d = 1'b1;
            fill_addr_d   = 20'd0;
            fill_color_d  = fill_color;
        end else begin
            fill_active_d = fill_active_q;
        end
`endif

        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (dispatch_ok_s) begin
                    if (fill_word_s) begin
`ifdef DISPLAY_FILL_EN
                        disp_addr_d = fill_addr_q;
                        disp_data_d = fill_color_q;
                        fill_addr_d = fill_addr_q + ADDR_ONE;
`endif
                        disp_wr_d   = 1'b1;
                        cnt_d       = 8'd0;
                        state_d     = ST_WRITE;
                    end else if (fill_done_s) begin
                        // Last fill word has cleared WAIT; release the bus.
`ifdef DISPLAY_FILL_EN
                        fill_active_d = 1'b0;
`endif
                        state_d = ST_IDLE;
                    end else if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        rd_ptr_d    = rd_ptr_q + PTR_ONE;
                        disp_addr_d = mem_q[rd_ptr_q][35:16];
                        disp_data_d = mem_q[rd_ptr_q][15:0];
                        disp_wr_d   = 1'b1;
                        cnt_d       = 8'd0;
                        state_d     = ST_WRITE;
                    end else if (flip_pending_q) begin
                        // Everything queued ahead of the flip has been written.
                        flip_d  = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = ST_FLIP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_WRITE: begin
                if (cnt_q == WR_LAST) begin
                    disp_wr_d = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = ST_GUARD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_GUARD: begin
                // display_busy may still be low here because the display stage
                // has not caught up yet, so it is deliberately not looked at.
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_FLIP: begin
                if (cnt_q == FLIP_LAST) begin
                    flip_d         = 1'b0;
                    flip_pending_d = 1'b0;
                    cnt_d          = 8'd0;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = 8'd0;
                disp_wr_d = 1'b0;
                flip_d    = 1'b0;
            end
        endcase
    end

    // FIFO write pointer and occupancy; push and pop may coincide.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + LVL_ONE;
            2'b01:   count_d = count_q - LVL_ONE;
            default: count_d = count_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // Control and output registers; reset discards queued data and drops strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 8'd0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            flip_pending_q <= 1'b0;
            disp_addr_q    <= 20'd0;
            disp_data_q    <= 16'd0;
            disp_wr_q      <= 1'b0;
            flip_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            flip_pending_q <= flip_pending_d;
            disp_addr_q    <= disp_addr_d;
            disp_data_q    <= disp_data_d;
            disp_wr_q      <= disp_wr_d;
            flip_q         <= flip_d;
        end
    end

    // FIFO storage: plain datapath memory, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {wr_addr, wr_data};
        end
    end

`ifdef DISPLAY_FILL_EN
    // Fill engine registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_active_q <= 1'b0;
            fill_addr_q   <= 20'd0;
            fill_color_q  <= 16'd0;
        end else begin
            fill_active_q <= fill_active_d;
            fill_addr_q   <= fill_addr_d;
            fill_color_q  <= fill_color_d;
        end
    end

    assign fill_busy = fill_active_q;
`endif

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign wr_ready                 = wr_ready_s;
    assign flip_pending             = flip_pending_q;
    assign level                    = count_q;
    assign display_addr             = disp_addr_q;
    assign display_data             = disp_data_q;
    assign display_wr               = disp_wr_q;
    assign display_flip_framebuffer = flip_q;

endmodule

// File: tb/tb_display_write_queue.sv
// Self-checking bench for display_write_queue.
// A negedge monitor logs every display_wr and flip pulse.
// Scenario tasks compare those logs against a queue-based model of
// "writes leave in accept order, each held 2 cycles, >= 7 cycles apart, and a
// flip fires only once every write accepted before it has been written".
module tb_display_write_queue;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int HOLD  = 2;
    localparam int SPACE = 7;
    localparam int PULSE = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [19:0] wr_addr = 20'd0;
    logic [15:0] wr_data = 16'd0;
    logic        flip_req = 1'b0;
    logic        display_busy = 1'b0;
    logic        wr_ready, flip_pending, display_wr, display_flip_framebuffer;
    logic [LW-1:0] level;
    logic [19:0] display_addr;
    logic [15:0] display_data;
`ifdef DISPLAY_FILL_EN
    logic        fill_start = 1'b0;
    logic [15:0] fill_color = 16'd0;
    logic        fill_busy;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_accept = 0;

    // Monitor logs.
    int          wr_cyc[$];
    logic [19:0] wr_a[$];
    logic [15:0] wr_d[$];
    int          wr_len[$];
    int          fl_cyc[$];
    int          fl_len[$];
    int          fl_wcnt[$];
    int          stable_err = 0;

    // Reference model.
    logic [19:0] exp_a[$];
    logic [15:0] exp_d[$];
    int          exp_flip[$];
    int          chk_idx = 0;

    display_write_queue #(.DEPTH(DEPTH), .FB_PIXELS(8)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .wr_valid                 (wr_valid),
        .wr_addr                  (wr_addr),
        .wr_data                  (wr_data),
        .wr_ready                 (wr_ready),
        .flip_req                 (flip_req),
        .flip_pending             (flip_pending),
        .level                    (level),
`ifdef DISPLAY_FILL_EN
        .fill_start               (fill_start),
        .fill_color               (fill_color),
        .fill_busy                (fill_busy),
`endif
        .display_addr             (display_addr),
        .display_data             (display_data),
        .display_wr               (display_wr),
        .display_busy             (display_busy),
        .display_flip_framebuffer (display_flip_framebuffer)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log write/flip pulses and catch address/data changing between writes.
    initial begin
        logic        prev_wr, prev_fl, prev_rst;
        logic [19:0] prev_a;
        logic [15:0] prev_d;
        int run_wr, run_fl;
        prev_wr = 1'b0; prev_fl = 1'b0; prev_rst = 1'b0;
        prev_a = 20'd0; prev_d = 16'd0; run_wr = 0; run_fl = 0;
        forever begin
            @(negedge clk);
            if (display_wr && !prev_wr) begin
                wr_cyc.push_back(cyc);
                wr_a.push_back(display_addr);
                wr_d.push_back(display_data);
                run_wr = 1;
            end else if (display_wr) begin
                run_wr++;
            end
            if (!display_wr && prev_wr) wr_len.push_back(run_wr);
            if (reset_n && prev_rst && !(display_wr && !prev_wr) &&
                (display_addr !== prev_a || display_data !== prev_d)) stable_err++;
            if (display_flip_framebuffer && !prev_fl) begin
                fl_cyc.push_back(cyc);
                fl_wcnt.push_back(wr_cyc.size());
                run_fl = 1;
            end else if (display_flip_framebuffer) begin
                run_fl++;
            end
            if (!display_flip_framebuffer && prev_fl) fl_len.push_back(run_fl);
            prev_wr = display_wr; prev_fl = display_flip_framebuffer; prev_rst = reset_n;
            prev_a = display_addr; prev_d = display_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drive one write; wr_valid is high only across the accepting edge.
    task automatic push(input logic [19:0] a, input logic [15:0] d);
        int t = 0;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        while (!wr_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!wr_ready) begin
            tests++; fails++;
            $display("FAIL push_accept: wr_ready=%b required 1", wr_ready);
        end else begin
            exp_a.push_back(a);
            exp_d.push_back(d);
        end
        @(posedge clk);
        #1;
        last_accept = cyc;
        wr_valid = 1'b0;
    endtask

    // Wait for all modelled writes to appear and compare them in order.
    task automatic check_drain(input string tag);
        int n = exp_a.size();
        int t = 0;
        while (wr_len.size() < chk_idx + n && t < 3000) begin
            step();
            t++;
        end
        tests++;
        if (wr_len.size() < chk_idx + n) begin
            fails++;
            $display("FAIL %s_count: got %0d writes required %0d", tag, wr_len.size() - chk_idx, n);
        end else begin
            for (int k = 0; k < n; k++) begin
                int idx = chk_idx + k;
                tests++;
                if (wr_a[idx] !== exp_a[k] || wr_d[idx] !== exp_d[k]) begin
                    fails++;
                    $display("FAIL %s_word%0d: got %05h/%04h required %05h/%04h",
                             tag, k, wr_a[idx], wr_d[idx], exp_a[k], exp_d[k]);
                end
                tests++;
                if (wr_len[idx] !== HOLD) begin
                    fails++;
                    $display("FAIL %s_hold%0d: got %0d cycles required %0d", tag, k, wr_len[idx], HOLD);
                end
                if (k > 0) begin
                    tests++;
                    if (wr_cyc[idx] - wr_cyc[idx - 1] < SPACE) begin
                        fails++;
                        $display("FAIL %s_spacing%0d: got %0d cycles required >= %0d",
                                 tag, k, wr_cyc[idx] - wr_cyc[idx - 1], SPACE);
                    end
                end
            end
        end
        chk_idx = wr_cyc.size();
        exp_a.delete();
        exp_d.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready: got %b required 1", wr_ready); end
        tests++; if (level !== '0) begin fails++; $display("FAIL reset_level: got %0d required 0", level); end
        tests++; if (flip_pending !== 1'b0) begin fails++; $display("FAIL reset_flip_pending: got %b required 0", flip_pending); end
        tests++; if (display_wr !== 1'b0) begin fails++; $display("FAIL reset_display_wr: got %b required 0", display_wr); end
        tests++; if (display_flip_framebuffer !== 1'b0) begin fails++; $display("FAIL reset_flip: got %b required 0", display_flip_framebuffer); end
        tests++; if (display_addr !== 20'd0 || display_data !== 16'd0) begin
            fails++; $display("FAIL reset_display_bus: got %05h/%04h required 0/0", display_addr, display_data);
        end
        reset_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_single_write();
        int base = wr_cyc.size();
        int acc;
        push(20'h00010, 16'hF800);
        acc = last_accept;
        check_drain("single");
        tests++;
        if (wr_cyc[base] !== acc + 1) begin
            fails++; $display("FAIL single_latency: got %0d cycles required 1", wr_cyc[base] - acc);
        end
        repeat (10) step();
        tests++; if (level !== '0) begin fails++; $display("FAIL single_level: got %0d required 0", level); end
        tests++; if (display_addr !== 20'h00010 || display_data !== 16'hF800) begin
            fails++; $display("FAIL single_held: got %05h/%04h required 00010/f800", display_addr, display_data);
        end
    endtask

    task automatic test_back_to_back();
        int base = wr_cyc.size();
        step();
        display_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push(20'($urandom_range(0, 20'hFFFFF)), 16'($urandom_range(0, 16'hFFFF)));
        end
        step();
        tests++; if (level !== LW'(DEPTH)) begin fails++; $display("FAIL b2b_level: got %0d required %0d", level, DEPTH); end
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready: got %b required 0", wr_ready); end
        repeat (5) step();
        tests++; if (wr_cyc.size() !== base) begin
            fails++; $display("FAIL b2b_busy_hold: got %0d writes required 0", wr_cyc.size() - base);
        end
        display_busy = 1'b0;
        check_drain("b2b");
    endtask

    task automatic test_flip();
        int base = wr_cyc.size();
        int fbase = fl_cyc.size();
        int t = 0;
        for (int i = 0; i < 3; i++) push(20'h00100 + 20'(i), 16'h1234 + 16'(i));
        @(negedge clk);
        flip_req = 1'b1;
        @(posedge clk);
        #1;
        flip_req = 1'b0;
        step();
        tests++; if (flip_pending !== 1'b1) begin fails++; $display("FAIL flip_pending_set: got %b required 1", flip_pending); end
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL flip_blocks_ready: got %b required 0", wr_ready); end
        while (fl_len.size() <= fbase && t < 1000) begin step(); t++; end
        tests++;
        if (fl_len.size() <= fbase) begin
            fails++; $display("FAIL flip_timeout: got no flip pulse required 1");
        end else begin
            tests++; if (fl_wcnt[fbase] !== base + 3) begin
                fails++; $display("FAIL flip_order: got %0d writes before flip required 3", fl_wcnt[fbase] - base);
            end
            tests++; if (wr_cyc.size() < base + 3 || fl_cyc[fbase] < wr_cyc[base + 2] + SPACE) begin
                fails++; $display("FAIL flip_after_wait: got flip at %0d required >= last write + %0d", fl_cyc[fbase], SPACE);
            end
            tests++; if (fl_len[fbase] !== PULSE) begin fails++; $display("FAIL flip_pulse: got %0d required %0d", fl_len[fbase], PULSE); end
            tests++; if (flip_pending !== 1'b0 || wr_ready !== 1'b1) begin
                fails++; $display("FAIL flip_release: got pending=%b ready=%b required 0/1", flip_pending, wr_ready);
            end
        end
        check_drain("flip");
    endtask

    task automatic test_busy_guard();
        int base = wr_cyc.size();
        int t = 0;
        int fall;
        push(20'h0ABCD, 16'h001F);
        push(20'h0ABCE, 16'h07E0);
        while (wr_cyc.size() <= base && t < 100) begin step(); t++; end
        repeat (3) step();
        display_busy = 1'b1;
        repeat (10) step();
        display_busy = 1'b0;
        fall = cyc;
        check_drain("busy");
        tests++;
        if (wr_cyc.size() < base + 2 || wr_cyc[base + 1] <= fall) begin
            fails++; $display("FAIL busy_guard: got second write cycle %0d required > %0d",
                              (wr_cyc.size() >= base + 2) ? wr_cyc[base + 1] : -1, fall);
        end
    endtask

    task automatic test_reset_mid_write();
        int base = wr_cyc.size();
        int t = 0;
        push(20'h00001, 16'hAAAA);
        push(20'h00002, 16'hBBBB);
        push(20'h00003, 16'hCCCC);
        while (wr_cyc.size() <= base && t < 100) begin step(); t++; end
        tests++; if (display_wr !== 1'b1) begin fails++; $display("FAIL rst_pre_write: got %b required 1", display_wr); end
        reset_n = 1'b0;
        #1;
        tests++; if (display_wr !== 1'b0) begin fails++; $display("FAIL rst_async_wr: got %b required 0", display_wr); end
        repeat (2) step();
        reset_n = 1'b1;
        exp_a.delete();
        exp_d.delete();
        repeat (30) step();
        tests++; if (level !== '0) begin fails++; $display("FAIL rst_level: got %0d required 0", level); end
        tests++; if (wr_cyc.size() !== base + 1) begin
            fails++; $display("FAIL rst_stale_write: got %0d writes required 1", wr_cyc.size() - base);
        end
        chk_idx = wr_cyc.size();
    endtask

    task automatic test_random();
        int fbase = fl_cyc.size();
        int t = 0;
        exp_flip.delete();
        for (int i = 0; i < 400; i++) begin
            step();
            display_busy = ($urandom_range(0, 9) < 3);
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr = 20'($urandom_range(0, 20'hFFFFF));
            wr_data = 16'($urandom_range(0, 16'hFFFF));
            flip_req = ($urandom_range(0, 24) == 0);
            if (wr_valid && wr_ready) begin
                exp_a.push_back(wr_addr);
                exp_d.push_back(wr_data);
            end
            if (flip_req && !flip_pending) exp_flip.push_back(chk_idx + exp_a.size());
        end
        step();
        wr_valid = 1'b0; flip_req = 1'b0; display_busy = 1'b0;
        check_drain("random");
        while (fl_len.size() < fbase + exp_flip.size() && t < 1000) begin step(); t++; end
        tests++;
        if (fl_len.size() !== fbase + exp_flip.size()) begin
            fails++; $display("FAIL random_flip_count: got %0d required %0d", fl_len.size() - fbase, exp_flip.size());
        end else begin
            for (int k = 0; k < exp_flip.size(); k++) begin
                tests++;
                if (fl_wcnt[fbase + k] !== exp_flip[k] || fl_len[fbase + k] !== PULSE) begin
                    fails++; $display("FAIL random_flip%0d: got writes=%0d len=%0d required writes=%0d len=%0d",
                                      k, fl_wcnt[fbase + k], fl_len[fbase + k], exp_flip[k], PULSE);
                end
            end
        end
    endtask

`ifdef DISPLAY_FILL_EN
    task automatic test_fill();
        int base = wr_cyc.size();
        int fbase = fl_cyc.size();
        int t = 0;
        int fall;
        step();
        fill_color = 16'h07E0;
        fill_start = 1'b1;
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        step();
        tests++; if (fill_busy !== 1'b1 || wr_ready !== 1'b0) begin
            fails++; $display("FAIL fill_start: got busy=%b ready=%b required 1/0", fill_busy, wr_ready);
        end
        @(negedge clk);
        flip_req = 1'b1;
        @(posedge clk);
        #1;
        flip_req = 1'b0;
        while (fill_busy && t < 2000) begin step(); t++; end
        fall = cyc;
        tests++;
        if (wr_cyc.size() !== base + 8) begin
            fails++; $display("FAIL fill_count: got %0d writes required 8", wr_cyc.size() - base);
        end else begin
            for (int k = 0; k < 8; k++) begin
                tests++;
                if (wr_a[base + k] !== 20'(k) || wr_d[base + k] !== 16'h07E0) begin
                    fails++; $display("FAIL fill_word%0d: got %05h/%04h required %05h/07e0", k, wr_a[base + k], wr_d[base + k], k);
                end
            end
            tests++; if (fall < wr_cyc[base + 7] + SPACE) begin
                fails++; $display("FAIL fill_busy_end: got fall at %0d required >= %0d", fall, wr_cyc[base + 7] + SPACE);
            end
        end
        t = 0;
        while (fl_len.size() <= fbase && t < 200) begin step(); t++; end
        tests++;
        if (fl_len.size() <= fbase || fl_wcnt[fbase] !== base + 8) begin
            fails++; $display("FAIL fill_flip_order: got flips=%0d required flip after 8 writes", fl_len.size() - fbase);
        end
        chk_idx = wr_cyc.size();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_flip();
        test_busy_guard();
        test_reset_mid_write();
        test_random();
`ifdef DISPLAY_FILL_EN
        test_fill();
`endif
        tests++;
        if (stable_err !== 0) begin
            fails++; $display("FAIL bus_stable: got %0d changes between writes required 0", stable_err);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
